// File: rtl/mem_stage_banked.sv
// MEM pipeline stage with a byte-lane-banked data memory.
// Handles byte/half/word loads and stores with alignment and range checks.
// Misaligned or out-of-range accesses raise sticky fault flags.
// A handshaked dump engine streams every word out to the debug unit.
module mem_stage_banked #(
    parameter int NB           = 32,
    parameter int TAM          = 16,
    parameter int NB_SIZE_TYPE = 3
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_step,
    input  logic [NB-1:0]           i_alu_address_result,
    input  logic                    i_mem_read,
    input  logic                    i_mem_write,
    input  logic                    i_signed,
    input  logic [NB_SIZE_TYPE-1:0] i_word_size,
    input  logic [NB-1:0]           i_data_b_to_write,
    input  logic                    i_branch,
    input  logic                    i_cero,
    input  logic [NB-1:0]           i_debug_address,
    input  logic                    i_clear_fault,
    input  logic                    i_dump_start,
    input  logic                    i_dump_ready,
    output logic [NB-1:0]           o_data_memory,
    output logic                    o_read_valid,
    output logic [NB-1:0]           o_data_debug_memory,
    output logic                    o_branch_zero,
    output logic                    o_misaligned,
    output logic                    o_out_of_range,
    output logic                    o_busy,
    output logic [NB-1:0]           o_dump_data,
    output logic [NB-1:0]           o_dump_addr,
    output logic                    o_dump_valid,
    output logic                    o_dump_done
);

    localparam int NBY  = NB / 8;
    localparam int OFFW = $clog2(NBY);
    localparam int AW   = $clog2(TAM);

    localparam logic [NB_SIZE_TYPE-1:0] SZ_BYTE = NB_SIZE_TYPE'(1);
    localparam logic [NB_SIZE_TYPE-1:0] SZ_HALF = NB_SIZE_TYPE'(2);
    localparam logic [NB_SIZE_TYPE-1:0] SZ_WORD = NB_SIZE_TYPE'(4);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DUMP,
        ST_DONE
    } dump_state_t;

    // One 8-bit bank per byte lane; a word is the concatenation of all lanes.
    logic [7:0] bank [NBY][TAM];

    logic [OFFW-1:0] offset;
    logic [OFFW-1:0] offset_hi;
    logic [NB-1:0]   word_idx;
    logic [AW-1:0]   word_sel;
    logic            out_of_range;
    logic            misaligned;
    logic            acc;
    logic            fault;
    logic            do_write;
    logic            do_read;

    logic [NBY-1:0]  lane_we;
    logic [7:0]      lane_data [NBY];
    logic [NB-1:0]   load_word;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [NB-1:0]   load_ext;

    logic [NB-1:0]   dbg_idx;
    logic [AW-1:0]   dbg_sel;
    logic [NB-1:0]   dbg_word;
    logic            dbg_unused;

    dump_state_t     state, state_next;
    logic [AW-1:0]   cnt, cnt_next;
    logic [NB-1:0]   dump_word;

    assign o_branch_zero = i_branch & i_cero;

    // Word reads ignore the byte-offset bits of the debug address.
    assign dbg_unused = ^i_debug_address[OFFW-1:0];

    // Split the pipeline address and classify the access as legal or faulting.
    always_comb begin
        offset       = i_alu_address_result[OFFW-1:0];
        offset_hi    = offset + OFFW'(1);
        word_idx     = i_alu_address_result >> OFFW;
        word_sel     = word_idx[AW-1:0];
        out_of_range = (word_idx >= NB'(TAM));
        case (i_word_size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = offset[0];
            SZ_WORD: misaligned = (offset != '0);
            default: misaligned = 1'b1;
        endcase
        acc      = i_step & (i_mem_read | i_mem_write) & ~o_busy;
        fault    = misaligned | out_of_range;
        do_write = acc & i_mem_write & ~fault;
        do_read  = acc & i_mem_read;
    end

    // Work out which lanes a store touches and the byte each one receives.
    always_comb begin
        for (int l = 0; l < NBY; l++) begin
            lane_we[l]   = 1'b0;
            lane_data[l] = 8'h00;
            case (i_word_size)
                SZ_BYTE: begin
                    lane_we[l]   = (OFFW'(l) == offset);
                    lane_data[l] = i_data_b_to_write[7:0];
                end
                SZ_HALF: begin
                    if (OFFW'(l) == offset) begin
                        lane_we[l]   = 1'b1;
                        lane_data[l] = i_data_b_to_write[7:0];
                    end else if (OFFW'(l) == offset_hi) begin
                        lane_we[l]   = 1'b1;
                        lane_data[l] = i_data_b_to_write[15:8];
                    end
                end
                SZ_WORD: begin
                    lane_we[l]   = 1'b1;
                    lane_data[l] = i_data_b_to_write[8*l +: 8];
                end
                default: begin
                    lane_we[l]   = 1'b0;
                    lane_data[l] = 8'h00;
                end
            endcase
        end
    end

    // Gather the addressed words for the pipeline, debug and dump read ports.
    always_comb begin
        dbg_idx = i_debug_address >> OFFW;
        dbg_sel = dbg_idx[AW-1:0];
        for (int l = 0; l < NBY; l++) begin
            load_word[8*l +: 8] = bank[l][word_sel];
            dbg_word[8*l +: 8]  = bank[l][dbg_sel];
            dump_word[8*l +: 8] = bank[l][cnt];
        end
        o_data_debug_memory = (dbg_idx >= NB'(TAM)) ? '0 : dbg_word;
    end

    // Pick the byte or half at the offset and extend it to full width.
    always_comb begin
        byte_sel = load_word[{offset, 3'b000} +: 8];
        half_sel = load_word[{offset[OFFW-1:1], 4'b0000} +: 16];
        case (i_word_size)
            SZ_BYTE: load_ext = {{(NB-8){i_signed & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_ext = {{(NB-16){i_signed & half_sel[15]}}, half_sel};
            default: load_ext = load_word;
        endcase
    end

    // Memory banks: cleared on reset, per-lane write on a legal store.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int l = 0; l < NBY; l++) begin
                for (int w = 0; w < TAM; w++) begin
                    bank[l][w] <= 8'h00;
                end
            end
        end else if (do_write) begin
            for (int l = 0; l < NBY; l++) begin
                if (lane_we[l]) begin
                    bank[l][word_sel] <= lane_data[l];
                end
            end
        end
    end

    // Registered load result; a faulting load still completes with zero data.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_data_memory <= '0;
            o_read_valid  <= 1'b0;
        end else begin
            o_read_valid <= do_read;
            if (do_read) begin
                o_data_memory <= fault ? '0 : load_ext;
            end
        end
    end

    // Sticky fault flags; a new fault in the same cycle beats a clear.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_misaligned   <= 1'b0;
            o_out_of_range <= 1'b0;
        end else begin
            if (acc & misaligned) begin
                o_misaligned <= 1'b1;
            end else if (i_clear_fault) begin
                o_misaligned <= 1'b0;
            end
            if (acc & out_of_range) begin
                o_out_of_range <= 1'b1;
            end else if (i_clear_fault) begin
                o_out_of_range <= 1'b0;
            end
        end
    end

    // Dump engine state and word counter registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Dump engine next state and handshake outputs.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        o_busy       = (state != ST_IDLE);
        o_dump_valid = 1'b0;
        o_dump_data  = '0;
        o_dump_addr  = '0;
        o_dump_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_dump_start) begin
                    state_next = ST_DUMP;
                    cnt_next   = '0;
                end
            end
            ST_DUMP: begin
                o_dump_valid = 1'b1;
                o_dump_data  = dump_word;
                o_dump_addr  = NB'(cnt) << OFFW;
                if (i_dump_ready) begin
                    if (cnt == AW'(TAM - 1)) begin
                        state_next = ST_DONE;
                    end else begin
                        cnt_next = cnt + AW'(1);
                    end
                end
            end
            ST_DONE: begin
                o_dump_done = 1'b1;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stage_banked.sv
// Directed self-checking bench for mem_stage_banked (NB=32, TAM=16).
module tb_mem_stage_banked;

    localparam int NB  = 32;
    localparam int TAM = 16;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_step;
    logic [NB-1:0] i_alu_address_result;
    logic          i_mem_read;
    logic          i_mem_write;
    logic          i_signed;
    logic [2:0]    i_word_size;
    logic [NB-1:0] i_data_b_to_write;
    logic          i_branch;
    logic          i_cero;
    logic [NB-1:0] i_debug_address;
    logic          i_clear_fault;
    logic          i_dump_start;
    logic          i_dump_ready;
    logic [NB-1:0] o_data_memory;
    logic          o_read_valid;
    logic [NB-1:0] o_data_debug_memory;
    logic          o_branch_zero;
    logic          o_misaligned;
    logic          o_out_of_range;
    logic          o_busy;
    logic [NB-1:0] o_dump_data;
    logic [NB-1:0] o_dump_addr;
    logic          o_dump_valid;
    logic          o_dump_done;

    int num_compared   = 0;
    int num_mismatched = 0;

    mem_stage_banked #(.NB(NB), .TAM(TAM), .NB_SIZE_TYPE(3)) dut (
        .i_clk                (i_clk),
        .i_reset              (i_reset),
        .i_step               (i_step),
        .i_alu_address_result (i_alu_address_result),
        .i_mem_read           (i_mem_read),
        .i_mem_write          (i_mem_write),
        .i_signed             (i_signed),
        .i_word_size          (i_word_size),
        .i_data_b_to_write    (i_data_b_to_write),
        .i_branch             (i_branch),
        .i_cero               (i_cero),
        .i_debug_address      (i_debug_address),
        .i_clear_fault        (i_clear_fault),
        .i_dump_start         (i_dump_start),
        .i_dump_ready         (i_dump_ready),
        .o_data_memory        (o_data_memory),
        .o_read_valid         (o_read_valid),
        .o_data_debug_memory  (o_data_debug_memory),
        .o_branch_zero        (o_branch_zero),
        .o_misaligned         (o_misaligned),
        .o_out_of_range       (o_out_of_range),
        .o_busy               (o_busy),
        .o_dump_data          (o_dump_data),
        .o_dump_addr          (o_dump_addr),
        .o_dump_valid         (o_dump_valid),
        .o_dump_done          (o_dump_done)
    );

    // Free-running 10 ns clock.
    always #5 i_clk = ~i_clk;

    // Fill pattern used before the dump: word i gets a distinct value.
    function automatic logic [31:0] patt(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {8'hA5, b, ~b, 8'(i * 3)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_compared++;
        if (got !== exp) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one pipeline cycle from a negedge, then return the pipeline inputs to idle.
    task automatic applyStimulus(input logic step, input logic rd, input logic wr, input logic sgn,
                                 input logic [2:0] size, input logic [31:0] addr,
                                 input logic [31:0] data, input logic clr);
        i_step               = step;
        i_mem_read           = rd;
        i_mem_write          = wr;
        i_signed             = sgn;
        i_word_size          = size;
        i_alu_address_result = addr;
        i_data_b_to_write    = data;
        i_clear_fault        = clr;
        @(negedge i_clk);
        i_step        = 1'b0;
        i_mem_read    = 1'b0;
        i_mem_write   = 1'b0;
        i_clear_fault = 1'b0;
    endtask

    task automatic checkDebug(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        i_debug_address = addr;
        #1;
        checkOutput(tag, o_data_debug_memory, exp);
    endtask

    int xfer;
    int done_cnt;
    logic rdy;

    initial begin
        i_reset = 1'b1; i_step = 0; i_alu_address_result = 0; i_mem_read = 0;
        i_mem_write = 0; i_signed = 0; i_word_size = 3'b100; i_data_b_to_write = 0;
        i_branch = 0; i_cero = 0; i_debug_address = 0; i_clear_fault = 0;
        i_dump_start = 0; i_dump_ready = 0;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;

        checkOutput("rst_data", o_data_memory, 0);
        checkOutput("rst_valid", 32'(o_read_valid), 0);
        checkOutput("rst_mis", 32'(o_misaligned), 0);
        checkOutput("rst_oor", 32'(o_out_of_range), 0);
        checkOutput("rst_busy", 32'(o_busy), 0);
        checkOutput("rst_dvalid", 32'(o_dump_valid), 0);
        checkDebug("rst_mem8", 32'h8, 0);

        // Word store then word load with one-cycle latency
        applyStimulus(1, 0, 1, 0, 3'b100, 32'h8, 32'hDEADBEEF, 0);
        checkDebug("st_word", 32'h8, 32'hDEADBEEF);
        applyStimulus(1, 1, 0, 0, 3'b100, 32'h8, 0, 0);
        checkOutput("ld_word", o_data_memory, 32'hDEADBEEF);
        checkOutput("ld_valid", 32'(o_read_valid), 1);
        applyStimulus(0, 0, 0, 0, 3'b100, 32'h8, 0, 0);
        checkOutput("valid_pulse", 32'(o_read_valid), 0);
        checkOutput("data_hold", o_data_memory, 32'hDEADBEEF);

        // Byte store and extended loads
        applyStimulus(1, 0, 1, 0, 3'b001, 32'h9, 32'hAAAAAA80, 0);
        applyStimulus(1, 1, 0, 1, 3'b001, 32'h9, 0, 0);
        checkOutput("ld_sbyte", o_data_memory, 32'hFFFFFF80);
        applyStimulus(1, 1, 0, 0, 3'b001, 32'h9, 0, 0);
        checkOutput("ld_ubyte", o_data_memory, 32'h00000080);
        applyStimulus(1, 1, 0, 0, 3'b100, 32'h8, 0, 0);
        checkOutput("ld_word2", o_data_memory, 32'hDEAD80EF);
        applyStimulus(1, 1, 0, 1, 3'b010, 32'hA, 0, 0);
        checkOutput("ld_shalf_hi", o_data_memory, 32'hFFFFDEAD);

        // Half store and half loads
        applyStimulus(1, 0, 1, 0, 3'b010, 32'hA, 32'h55551234, 0);
        checkDebug("st_half", 32'h8, 32'h123480EF);
        applyStimulus(1, 1, 0, 0, 3'b010, 32'hA, 0, 0);
        checkOutput("ld_uhalf", o_data_memory, 32'h00001234);
        applyStimulus(1, 1, 0, 1, 3'b010, 32'h8, 0, 0);
        checkOutput("ld_shalf_lo", o_data_memory, 32'hFFFF80EF);

        // Faults: misaligned store, out-of-range load, clear, set-beats-clear
        applyStimulus(1, 0, 1, 0, 3'b010, 32'h3, 32'h0000FFFF, 0);
        checkOutput("mis_flag", 32'(o_misaligned), 1);
        checkOutput("mis_no_oor", 32'(o_out_of_range), 0);
        checkDebug("mis_mem", 32'h0, 0);
        applyStimulus(1, 1, 0, 0, 3'b100, 32'h40, 0, 0);
        checkOutput("oor_flag", 32'(o_out_of_range), 1);
        checkOutput("oor_data", o_data_memory, 0);
        checkOutput("oor_valid", 32'(o_read_valid), 1);
        applyStimulus(0, 0, 0, 0, 3'b100, 0, 0, 1);
        checkOutput("clr_mis", 32'(o_misaligned), 0);
        checkOutput("clr_oor", 32'(o_out_of_range), 0);
        applyStimulus(1, 0, 1, 0, 3'b010, 32'h3, 32'h0000FFFF, 1);
        checkOutput("set_wins", 32'(o_misaligned), 1);
        applyStimulus(0, 0, 0, 0, 3'b100, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 3'b100, 32'h8, 0, 0);
        checkOutput("ld_word3", o_data_memory, 32'h123480EF);
        applyStimulus(1, 1, 0, 0, 3'b011, 32'h8, 0, 0);
        checkOutput("illegal_mis", 32'(o_misaligned), 1);
        checkOutput("illegal_data", o_data_memory, 0);
        applyStimulus(0, 0, 0, 0, 3'b100, 0, 0, 1);

        // Same-cycle read and write returns the old word
        applyStimulus(1, 0, 1, 0, 3'b100, 32'h10, 32'hCAFEF00D, 0);
        applyStimulus(1, 1, 1, 0, 3'b100, 32'h10, 32'h11223344, 0);
        checkOutput("rw_old", o_data_memory, 32'hCAFEF00D);
        checkDebug("rw_new", 32'h10, 32'h11223344);

        // No access without step
        applyStimulus(0, 0, 1, 0, 3'b100, 32'h10, 32'hFFFFFFFF, 0);
        checkDebug("nostep_mem", 32'h10, 32'h11223344);
        checkOutput("nostep_valid", 32'(o_read_valid), 0);

        // Branch zero
        i_branch = 1; i_cero = 1; #1;
        checkOutput("bz_11", 32'(o_branch_zero), 1);
        i_cero = 0; #1;
        checkOutput("bz_10", 32'(o_branch_zero), 0);
        i_branch = 0;
        @(negedge i_clk);

        // Fill memory with a known pattern, then dump with a stalling consumer
        for (int i = 0; i < TAM; i++) begin
            applyStimulus(1, 0, 1, 0, 3'b100, 32'(i * 4), patt(i), 0);
        end
        checkDebug("dbg_oor", 32'h40, 0);
        checkDebug("dbg_w5", 32'h14, patt(5));

        i_dump_start = 1;
        @(negedge i_clk);
        i_dump_start = 0;
        xfer = 0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (o_dump_done) done_cnt++;
            if (o_dump_valid) begin
                checkOutput("dump_data", o_dump_data, patt(xfer));
                checkOutput("dump_addr", o_dump_addr, 32'(xfer * 4));
            end
            if (k == 3) checkOutput("busy_load", 32'(o_read_valid), 0);
            rdy = (k % 3 != 1);
            i_dump_ready = rdy;
            i_step      = (k == 2);
            i_mem_write = (k == 2);
            i_mem_read  = (k == 2);
            i_word_size = 3'b100;
            i_alu_address_result = 0;
            i_data_b_to_write = 32'hFFFFFFFF;
            if (rdy && o_dump_valid) xfer++;
            @(negedge i_clk);
        end
        i_dump_ready = 0;
        checkOutput("dump_count", 32'(xfer), 16);
        checkOutput("dump_done", 32'(done_cnt), 1);
        checkOutput("dump_idle", 32'(o_busy), 0);
        checkDebug("busy_store", 32'h0, patt(0));

        // Reset in the middle of a dump
        i_dump_start = 1;
        i_dump_ready = 1;
        @(negedge i_clk);
        i_dump_start = 0;
        repeat (5) @(negedge i_clk);
        checkOutput("mid_addr", o_dump_addr, 32'h14);
        checkOutput("mid_busy", 32'(o_busy), 1);
        i_reset = 1;
        @(negedge i_clk);
        checkOutput("abort_busy", 32'(o_busy), 0);
        checkOutput("abort_valid", 32'(o_dump_valid), 0);
        checkOutput("abort_done", 32'(o_dump_done), 0);
        i_reset = 0;
        i_dump_ready = 0;
        @(negedge i_clk);
        checkOutput("abort_done2", 32'(o_dump_done), 0);
        checkOutput("abort_data", o_data_memory, 0);
        for (int i = 0; i < TAM; i++) begin
            checkDebug("abort_mem", 32'(i * 4), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
